// File: rtl/nand_target_pkg.sv
`default_nettype none
// nand_target_pkg: FSM state encoding, command opcodes and status bit positions
// shared by the NAND target and host-side models.  Rev 1.0
package nand_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ID_ADDR  = 4'd1,
    ST_ID_OUT   = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_BUSY  = 4'd4,
    ST_RD_OUT   = 4'd5,
    ST_PG_ADDR  = 4'd6,
    ST_PG_DATA  = 4'd7,
    ST_PG_BUSY  = 4'd8,
    ST_RST_BUSY = 4'd9
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h00;
  localparam logic [7:0] CMD_READ_CONF = 8'h30;
  localparam logic [7:0] CMD_PROG      = 8'h80;
  localparam logic [7:0] CMD_PROG_CONF = 8'h10;
  localparam logic [7:0] CMD_READ_ID   = 8'h90;
  localparam logic [7:0] CMD_STATUS    = 8'h70;
  localparam logic [7:0] CMD_RESET     = 8'hFF;

  localparam int STAT_FAIL  = 0;
  localparam int STAT_READY = 6;
  localparam int STAT_WP    = 7;

  function automatic logic is_busy(input state_t s);
    return (s == ST_RD_BUSY) || (s == ST_PG_BUSY) || (s == ST_RST_BUSY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nand_sync_edge.sv
`default_nettype none
// nand_sync_edge: 2-flop synchronizer for one asynchronous bus control, with
// single-clk rise/fall pulses derived from the synchronized level.  Rev 1.0
module nand_sync_edge #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);
  logic meta;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= INIT;
      sync_q <= INIT;
      prev_q <= INIT;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;
endmodule
`default_nettype wire

// File: rtl/nand_target.sv
`default_nettype none
// nand_target: single-page NAND flash target (read ID, page read, staged page
// program, status, reset) behind an asynchronous host bus.  Rev 1.0
module nand_target
  import nand_target_pkg::*;
#(
  parameter int          PAGE_BYTES = 64,
  parameter int          T_R        = 40,
  parameter int          T_PROG     = 80,
  parameter int          T_RST      = 20,
  parameter logic [39:0] ID_BYTES   = 40'h86_03_FF_E5_2C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nand_cle,
  input  logic       nand_ale,
  input  logic       nand_nwe,
  input  logic       nand_nce,
  input  logic       nand_nre,
  input  logic       nand_nwp,
  input  logic [7:0] nand_dq_i,
  output logic [7:0] nand_dq_o,
  output logic       nand_dq_oe,
  output logic       nand_rnb
);
  localparam int         AW        = $clog2(PAGE_BYTES);
  localparam int         CNT_W     = 16;
  // Bit order {nwp, nre, nce, nwe, ale, cle}; strobes and selects idle high.
  localparam logic [5:0] SYNC_INIT = 6'b011100;

  logic [5:0] pins, ctl_sync, ctl_rise, unused_fall;
  logic       unused_misc;

  assign pins = {nand_nwp, nand_nre, nand_nce, nand_nwe, nand_ale, nand_cle};

  for (genvar i = 0; i < 6; i++) begin : g_sync
    nand_sync_edge #(.INIT(SYNC_INIT[i])) u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (pins[i]),
      .sync_out (ctl_sync[i]),
      .rise     (ctl_rise[i]),
      .fall     (unused_fall[i])
    );
  end

  logic cle_s, ale_s, nce_s, nre_s, nwp_s;
  assign cle_s = ctl_sync[0];
  assign ale_s = ctl_sync[1];
  assign nce_s = ctl_sync[3];
  assign nre_s = ctl_sync[4];
  assign nwp_s = ctl_sync[5];
  assign unused_misc = ^{ctl_sync[2], ctl_rise[0], ctl_rise[1], ctl_rise[3], ctl_rise[5]};

  logic wr_strobe, cmd_latch, addr_latch, data_latch, rd_strobe;
  assign wr_strobe  = ctl_rise[2] & ~nce_s;
  assign cmd_latch  = wr_strobe & cle_s & ~ale_s;
  assign addr_latch = wr_strobe & ale_s & ~cle_s;
  assign data_latch = wr_strobe & ~cle_s & ~ale_s;
  assign rd_strobe  = ctl_rise[4] & ~nce_s;

  state_t                  state;
  logic [AW-1:0]           ptr;
  logic [2:0]              id_idx;
  logic [2:0]              addr_cnt;
  logic [7:0]              col_lo;
  logic [CNT_W-1:0]        busy_cnt;
  logic                    fail, status_mode, prog_ok;
  logic [PAGE_BYTES-1:0]   dirty;
  logic [7:0]              page_mem  [PAGE_BYTES];
  logic [7:0]              stage_mem [PAGE_BYTES];

  logic busy, stage_we, commit;
  assign busy     = is_busy(state);
  assign stage_we = data_latch && (state == ST_PG_DATA);
  assign commit   = !reset && (state == ST_PG_BUSY) && (busy_cnt == '0) && prog_ok;

  // Page and staging storage carry no reset: contents survive reset.
  always_ff @(posedge clk) begin
    if (stage_we) stage_mem[ptr] <= nand_dq_i;
    if (commit) begin
      for (int i = 0; i < PAGE_BYTES; i++) begin
        if (dirty[i]) page_mem[i] <= stage_mem[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      nand_rnb    <= 1'b1;
      ptr         <= '0;
      id_idx      <= '0;
      addr_cnt    <= '0;
      col_lo      <= '0;
      busy_cnt    <= '0;
      fail        <= 1'b0;
      status_mode <= 1'b0;
      prog_ok     <= 1'b0;
      dirty       <= '0;
    end else begin
      if (stage_we) begin
        dirty[ptr] <= 1'b1;
        ptr        <= ptr + AW'(1);
      end
      if (rd_strobe && !status_mode) begin
        if (state == ST_ID_OUT && id_idx < 3'd5) id_idx <= id_idx + 3'd1;
        if (state == ST_RD_OUT) ptr <= ptr + AW'(1);
      end
      if (busy) begin
        if (busy_cnt == '0) begin
          state    <= (state == ST_RD_BUSY) ? ST_RD_OUT : ST_IDLE;
          nand_rnb <= 1'b1;
        end else begin
          busy_cnt <= busy_cnt - CNT_W'(1);
        end
      end
      if (addr_latch && !busy) begin
        case (state)
          ST_ID_ADDR: begin
            state  <= ST_ID_OUT;
            id_idx <= '0;
          end
          ST_RD_ADDR, ST_PG_ADDR: begin
            if (addr_cnt == 3'd0) col_lo <= nand_dq_i;
            if (addr_cnt == 3'd1) ptr <= AW'({nand_dq_i, col_lo});
            if (addr_cnt != 3'd7) addr_cnt <= addr_cnt + 3'd1;
            if (state == ST_PG_ADDR && addr_cnt == 3'd4) state <= ST_PG_DATA;
          end
          default: ;
        endcase
      end
      // Commands are decoded last so 0xFF overrides any busy countdown above.
      if (cmd_latch) begin
        if (nand_dq_i == CMD_STATUS) begin
          status_mode <= 1'b1;
        end else if (nand_dq_i == CMD_RESET) begin
          state       <= ST_RST_BUSY;
          nand_rnb    <= 1'b0;
          busy_cnt    <= CNT_W'(T_RST - 1);
          dirty       <= '0;
          fail        <= 1'b0;
          prog_ok     <= 1'b0;
          status_mode <= 1'b0;
        end else if (!busy) begin
          status_mode <= 1'b0;
          case (nand_dq_i)
            CMD_READ_ID: state <= ST_ID_ADDR;
            CMD_READ: begin
              state    <= ST_RD_ADDR;
              addr_cnt <= '0;
            end
            CMD_PROG: begin
              state    <= ST_PG_ADDR;
              addr_cnt <= '0;
              dirty    <= '0;
              fail     <= 1'b0;
            end
            CMD_READ_CONF: begin
              if (state == ST_RD_ADDR && addr_cnt == 3'd5) begin
                state    <= ST_RD_BUSY;
                nand_rnb <= 1'b0;
                busy_cnt <= CNT_W'(T_R - 1);
              end
            end
            CMD_PROG_CONF: begin
              if (state == ST_PG_DATA) begin
                state    <= ST_PG_BUSY;
                nand_rnb <= 1'b0;
                busy_cnt <= CNT_W'(T_PROG - 1);
                fail     <= ~nwp_s;
                prog_ok  <= nwp_s;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  logic [7:0] status_byte, id_byte, rd_byte;

  always_comb begin
    status_byte             = '0;
    status_byte[STAT_WP]    = nwp_s;
    status_byte[STAT_READY] = ~busy;
    status_byte[STAT_FAIL]  = fail;
    case (id_idx)
      3'd0:    id_byte = ID_BYTES[7:0];
      3'd1:    id_byte = ID_BYTES[15:8];
      3'd2:    id_byte = ID_BYTES[23:16];
      3'd3:    id_byte = ID_BYTES[31:24];
      3'd4:    id_byte = ID_BYTES[39:32];
      default: id_byte = 8'h00;
    endcase
    if (status_mode)             rd_byte = status_byte;
    else if (state == ST_ID_OUT) rd_byte = id_byte;
    else                         rd_byte = page_mem[ptr];
  end

  assign nand_dq_oe = ~nce_s & ~nre_s &
                      (status_mode || state == ST_ID_OUT || state == ST_RD_OUT);
  assign nand_dq_o  = nand_dq_oe ? rd_byte : 8'h00;
endmodule
`default_nettype wire

// File: tb/tb_nand_target.sv
`default_nettype none
// tb_nand_target: directed host-bus stimulus; expected read bytes are queued
// and checked by a monitor each time the target drives and releases DQ.
module tb_nand_target;
  localparam int PAGE_BYTES = 64;
  localparam int T_R        = 40;
  localparam int T_PROG     = 80;
  localparam int T_RST      = 20;
  localparam int PERIOD     = 10;

  logic       clk = 1'b0, reset = 1'b1;
  logic       cle = 1'b0, ale = 1'b0, nwe = 1'b1, nce = 1'b1, nre = 1'b1, nwp = 1'b1;
  logic [7:0] dq_i = 8'h00;
  logic [7:0] dq_o;
  logic       dq_oe, rnb;

  always #(PERIOD / 2) clk = ~clk;

  nand_target #(
    .PAGE_BYTES (PAGE_BYTES),
    .T_R        (T_R),
    .T_PROG     (T_PROG),
    .T_RST      (T_RST),
    .ID_BYTES   (40'h86_03_FF_E5_2C)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .nand_cle   (cle),
    .nand_ale   (ale),
    .nand_nwe   (nwe),
    .nand_nce   (nce),
    .nand_nre   (nre),
    .nand_nwp   (nwp),
    .nand_dq_i  (dq_i),
    .nand_dq_o  (dq_o),
    .nand_dq_oe (dq_oe),
    .nand_rnb   (rnb)
  );

  int         n_checks = 0, n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_dq = 8'h00, exp_b;
  logic       oe_seen = 1'b0;
  int         oe_cycles = 0;
  int         low_run = 0, busy_len = 0;
  time        rise_time = 0, t_nwe = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Read-data monitor and ready/busy pulse-width monitor.
  always @(negedge clk) begin
    if (dq_oe === 1'b1) begin
      last_dq = dq_o;
      oe_seen = 1'b1;
      oe_cycles++;
    end else if (oe_seen) begin
      oe_seen = 1'b0;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected read: got 0x%0h, expected no DQ output", last_dq);
      end else begin
        exp_b = exp_q.pop_front();
        check("read dq", int'(last_dq), int'(exp_b));
      end
    end
    if (rnb === 1'b0) low_run++;
    else if (low_run > 0) begin
      busy_len  = low_run;
      rise_time = $time;
      low_run   = 0;
    end
  end

  task automatic bus_write(input logic c, input logic a, input logic [7:0] d, input logic ce);
    @(negedge clk);
    cle = c; ale = a; nce = ce; dq_i = d; nwe = 1'b0;
    repeat (4) @(negedge clk);
    nwe = 1'b1;
    t_nwe = $time;
    repeat (4) @(negedge clk);
    cle = 1'b0; ale = 1'b0; nce = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] d);
    bus_write(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic addr5(input logic [7:0] col);
    bus_write(1'b0, 1'b1, col, 1'b0);
    for (int i = 0; i < 4; i++) bus_write(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic data(input logic [7:0] d);
    bus_write(1'b0, 1'b0, d, 1'b0);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    nre = 1'b0;
    repeat (4) @(negedge clk);
    nre = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] e);
    exp_q.push_back(e);
    read_pulse();
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (rnb !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(name, int'(rnb), 1);
  endtask

  initial begin
    #(PERIOD * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int oe_before;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset rnb", int'(rnb), 1);
    check("reset dq_oe", int'(dq_oe), 0);
    check("reset dq_o", int'(dq_o), 0);
    reset = 1'b0;
    nce   = 1'b0;
    repeat (5) @(negedge clk);
    check("idle rnb", int'(rnb), 1);

    // Deselected and cle=ale=1 strobes must not change state
    bus_write(1'b1, 1'b0, 8'h90, 1'b1);
    bus_write(1'b1, 1'b1, 8'h70, 1'b0);
    bus_write(1'b0, 1'b1, 8'h00, 1'b0);
    oe_before = oe_cycles;
    read_pulse();
    check("ignored strobes dq_oe cycles", oe_cycles - oe_before, 0);

    // READ ID
    cmd(8'h90);
    bus_write(1'b0, 1'b1, 8'h00, 1'b0);
    rd(8'h2C); rd(8'hE5); rd(8'hFF); rd(8'h03); rd(8'h86); rd(8'h00);
    check("id queue drained", exp_q.size(), 0);

    // Program A5 5A at column 4, then read back
    cmd(8'h80); addr5(8'h04); data(8'hA5); data(8'h5A); cmd(8'h10);
    wait_ready("prog ready");
    check("prog rnb low clk", busy_len, T_PROG);
    check("prog rnb rise delay", int'((rise_time - t_nwe) / PERIOD), T_PROG + 3);
    cmd(8'h00); addr5(8'h04); cmd(8'h30);
    wait_ready("read ready");
    check("read rnb low clk", busy_len, T_R);
    rd(8'hA5); rd(8'h5A);
    check("prog queue drained", exp_q.size(), 0);

    // Write-protected program: fail status, page unchanged
    nwp = 1'b0;
    repeat (4) @(negedge clk);
    cmd(8'h80); addr5(8'h04); data(8'h11); data(8'h22); cmd(8'h10);
    wait_ready("wp prog ready");
    check("wp prog rnb low clk", busy_len, T_PROG);
    cmd(8'h70);
    rd(8'h41); rd(8'h41);
    nwp = 1'b1;
    repeat (4) @(negedge clk);
    rd(8'hC1);
    cmd(8'h00); addr5(8'h04); cmd(8'h30);
    wait_ready("wp readback ready");
    rd(8'hA5); rd(8'h5A);
    check("wp queue drained", exp_q.size(), 0);

    // Program wrapping from column 63 to column 0
    cmd(8'h80); addr5(8'h3F); data(8'h77); data(8'h88); cmd(8'h10);
    wait_ready("wrap prog ready");
    cmd(8'h00); addr5(8'h3F); cmd(8'h30);
    wait_ready("wrap read ready");
    rd(8'h77); rd(8'h88);
    cmd(8'h00); addr5(8'h00); cmd(8'h30);
    wait_ready("col0 read ready");
    rd(8'h88);
    cmd(8'h70);
    rd(8'hC0);
    check("wrap queue drained", exp_q.size(), 0);

    // 0xFF during read busy
    cmd(8'h00); addr5(8'h04); cmd(8'h30);
    repeat (10) @(negedge clk);
    check("mid read busy rnb", int'(rnb), 0);
    cmd(8'hFF);
    wait_ready("reset cmd ready");
    check("reset cmd rnb rise delay", int'((rise_time - t_nwe) / PERIOD), T_RST + 3);
    cmd(8'h70);
    rd(8'hC0);
    check("reset cmd queue drained", exp_q.size(), 0);

    // Synchronous reset mid-busy
    cmd(8'h00); addr5(8'h04); cmd(8'h30);
    repeat (5) @(negedge clk);
    check("pre-reset busy rnb", int'(rnb), 0);
    reset = 1'b1;
    @(negedge clk);
    check("reset ends busy", int'(rnb), 1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("final queue drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
